// File: rtl/wfifo_wr_arb_if.sv
// Purpose : bundles the write-side signals of the async FIFO between requesters/synchronizer and the arbiter.
// Latency : n/a (signal container only).
// Backpress: gnt is the only accept indication; a requester holds req until it sees gnt.
//
// Signals:
//   req, req_data      requester -> arbiter, one request bit and one DATA_WIDTH slice per requester
//   gnt                arbiter -> requester, one-hot combinational accept
//   rp2_wpt            synchronized Gray read pointer (read-to-write synchronizer output)
//   wpt                registered Gray write pointer (to write-to-read synchronizer)
//   wen, waddr, wdata  RAM write port
//   wfull, walmost_full, wlevel   registered status
interface wfifo_wr_arb_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 3
);
    logic [NREQ-1:0]            req;
    logic [NREQ*DATA_WIDTH-1:0] req_data;
    logic [NREQ-1:0]            gnt;
    logic [ADDR_WIDTH:0]        rp2_wpt;
    logic [ADDR_WIDTH:0]        wpt;
    logic                       wen;
    logic [ADDR_WIDTH-1:0]      waddr;
    logic [DATA_WIDTH-1:0]      wdata;
    logic                       wfull;
    logic                       walmost_full;
    logic [ADDR_WIDTH:0]        wlevel;

    // master: requesters plus synchronizer side; slave: the arbiter itself
    modport master (
        output req, req_data, rp2_wpt,
        input  gnt, wpt, wen, waddr, wdata, wfull, walmost_full, wlevel
    );

    modport slave (
        input  req, req_data, rp2_wpt,
        output gnt, wpt, wen, waddr, wdata, wfull, walmost_full, wlevel
    );
endinterface

// File: rtl/wfifo_wr_arb.sv
// Purpose : write-side controller of the async FIFO; round-robin shares one RAM write port among NREQ requesters.
// Latency : req -> gnt/wen/wdata combinational (0 cycles); pointers and flags update at the next WCLK edge.
// Backpress: gnt is withheld while wfull is set; requesters hold req until granted.
//
// Ports:
//   WCLK  write clock
//   WRST  synchronous active-high reset; also gates gnt/wen combinationally while high
//   bus   wfifo_wr_arb_if.slave: req/req_data in, gnt out, rp2_wpt in, wpt/wen/waddr/wdata and
//         wfull/walmost_full/wlevel out
module wfifo_wr_arb #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 3,
    parameter int AF_MARGIN  = 2
) (
    input  logic                 WCLK,
    input  logic                 WRST,
    wfifo_wr_arb_if.slave        bus
);
    localparam int AW    = ADDR_WIDTH;
    localparam int DEPTH = 2 ** AW;
    localparam int IDXW  = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDXW-1:0]       last_q;
    logic [AW:0]           wbin_q;
    logic [AW:0]           wpt_q;
    logic                  wfull_q;
    logic                  walmost_full_q;
    logic [AW:0]           wlevel_q;

    logic [NREQ-1:0]       gnt_c;
    logic [IDXW-1:0]       gnt_idx;
    logic [IDXW-1:0]       cand;
    logic                  found;
    logic [DATA_WIDTH-1:0] wdata_c;

    logic [AW:0]           wbin_next;
    logic [AW:0]           wgray_next;
    logic [AW:0]           rbin;
    logic [AW:0]           level_next;
    logic [AW+1:0]         free_next;
    logic                  full_next;
    logic                  af_next;

    // Round-robin search starting one past the last granted requester.
    // Reset and full both suppress the grant, so the search is skipped entirely.
    always_comb begin
        gnt_c   = '0;
        gnt_idx = last_q;
        cand    = last_q;
        found   = 1'b0;
        if (!WRST && !wfull_q) begin
            for (int k = 1; k <= NREQ; k++) begin
                cand = IDXW'((int'(last_q) + k) % NREQ);
                if (!found && bus.req[cand]) begin
                    found        = 1'b1;
                    gnt_c[cand]  = 1'b1;
                    gnt_idx      = cand;
                end
            end
        end
    end

    always_comb begin
        wdata_c = '0;
        if (found) begin
            wdata_c = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Gray-to-binary of the synchronized read pointer: bit i is the XOR of all bits at and above i.
    always_comb begin
        rbin = '0;
        for (int i = 0; i <= AW; i++) begin
            rbin[i] = ^(bus.rp2_wpt >> i);
        end
    end

    assign wbin_next  = wbin_q + {{AW{1'b0}}, found};
    assign wgray_next = wbin_next ^ (wbin_next >> 1);

    // Full when the write pointer is exactly one lap ahead: in Gray code that is the top two bits
    // inverted and the rest equal.
    assign full_next  = (wgray_next == {~bus.rp2_wpt[AW:AW-1], bus.rp2_wpt[AW-2:0]});
    assign level_next = wbin_next - rbin;
    assign free_next  = (AW+2)'(DEPTH) - {1'b0, level_next};
    assign af_next    = (free_next <= (AW+2)'(AF_MARGIN));

    always_ff @(posedge WCLK) begin
        if (WRST) begin
            last_q         <= IDXW'(NREQ - 1);
            wbin_q         <= '0;
            wpt_q          <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wlevel_q       <= '0;
        end else begin
            if (found) begin
                last_q <= gnt_idx;
            end
            wbin_q         <= wbin_next;
            wpt_q          <= wgray_next;
            wfull_q        <= full_next;
            walmost_full_q <= af_next;
            wlevel_q       <= level_next;
        end
    end

    assign bus.gnt          = gnt_c;
    assign bus.wen          = found;
    assign bus.waddr        = wbin_q[AW-1:0];
    assign bus.wdata        = wdata_c;
    assign bus.wpt          = wpt_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = walmost_full_q;
    assign bus.wlevel       = wlevel_q;
endmodule

// File: tb/tb_wfifo_wr_arb.sv
// Purpose : directed self-checking bench for wfifo_wr_arb (reset, round-robin, fill, release, wrap, mid-run reset).
// Latency : checks combinational outputs 1 time unit after inputs change, registered outputs 1 unit after WCLK rises.
// Backpress: requesters hold req; grants observed directly on gnt.
module tb_wfifo_wr_arb;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NR = 3;

    logic WCLK = 1'b0;
    logic WRST = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    wfifo_wr_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR)) bus ();

    wfifo_wr_arb #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .NREQ      (NR),
        .AF_MARGIN (2)
    ) dut (
        .WCLK(WCLK),
        .WRST(WRST),
        .bus (bus)
    );

    always #5 WCLK = ~WCLK;

    logic [DW-1:0] slice_val [NR];
    logic [AW:0]   d1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge WCLK);
        #1;
    endtask

    task automatic do_reset();
        WRST = 1'b1;
        tick();
        tick();
        WRST = 1'b0;
    endtask

    function automatic logic [AW:0] gray(input int b);
        logic [AW:0] v;
        v = AW'(0) + (AW+1)'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
        slice_val[0] = 8'h1A;
        slice_val[1] = 8'h3B;
        slice_val[2] = 8'h5C;
        bus.req      = 3'b111;
        bus.req_data = {slice_val[2], slice_val[1], slice_val[0]};
        bus.rp2_wpt  = '0;
        d1           = '0;

        // 1. reset with all requests held
        WRST = 1'b1;
        tick();
        tick();
        chk("rst_gnt",   32'(bus.gnt), 32'h0);
        chk("rst_wen",   32'(bus.wen), 32'h0);
        chk("rst_wpt",   32'(bus.wpt), 32'h0);
        chk("rst_wfull", 32'(bus.wfull), 32'h0);
        chk("rst_af",    32'(bus.walmost_full), 32'h0);
        chk("rst_level", 32'(bus.wlevel), 32'h0);
        WRST = 1'b0;
        #1;
        chk("rst_first_gnt", 32'(bus.gnt), 32'h1);

        // 2. round-robin with all requesters, then with 3'b101; rp2 tracks wpt
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr111_gnt%0d", i), 32'(bus.gnt), 32'(3'b001 << (i % 3)));
            chk($sformatf("rr111_dat%0d", i), 32'(bus.wdata), 32'(slice_val[i % 3]));
            tick();
            bus.rp2_wpt = bus.wpt;
        end
        bus.req = 3'b101;
        #1;
        chk("rr101_gnt0", 32'(bus.gnt), 32'h1);
        tick();
        bus.rp2_wpt = bus.wpt;
        #1;
        chk("rr101_gnt1", 32'(bus.gnt), 32'h4);
        chk("rr101_dat1", 32'(bus.wdata), 32'h5C);
        tick();
        bus.rp2_wpt = bus.wpt;
        #1;
        chk("rr101_gnt2", 32'(bus.gnt), 32'h1);

        // 3. fill to full from requester 0 with the read side frozen at 0
        do_reset();
        bus.req     = 3'b001;
        bus.rp2_wpt = '0;
        for (int i = 0; i < 16; i++) begin
            #1;
            chk($sformatf("fill_wen%0d", i),   32'(bus.wen), 32'h1);
            chk($sformatf("fill_addr%0d", i),  32'(bus.waddr), 32'(i));
            tick();
            chk($sformatf("fill_level%0d", i), 32'(bus.wlevel), 32'(i + 1));
            chk($sformatf("fill_af%0d", i),    32'(bus.walmost_full), ((i + 1) >= 14) ? 32'h1 : 32'h0);
            chk($sformatf("fill_full%0d", i),  32'(bus.wfull), ((i + 1) == 16) ? 32'h1 : 32'h0);
        end
        chk("full_wpt", 32'(bus.wpt), 32'h18);
        #1;
        chk("full_gnt", 32'(bus.gnt), 32'h0);
        chk("full_wen", 32'(bus.wen), 32'h0);
        tick();
        chk("full_hold", 32'(bus.wfull), 32'h1);
        chk("full_wpt_hold", 32'(bus.wpt), 32'h18);

        // 4. one entry drained: exactly one more write at address 0
        bus.rp2_wpt = 5'h01;
        #1;
        chk("drain_gnt_same", 32'(bus.gnt), 32'h0);
        tick();
        chk("drain_full", 32'(bus.wfull), 32'h0);
        chk("drain_level", 32'(bus.wlevel), 32'd15);
        #1;
        chk("drain_gnt", 32'(bus.gnt), 32'h1);
        chk("drain_addr", 32'(bus.waddr), 32'h0);
        tick();
        chk("refull", 32'(bus.wfull), 32'h1);
        chk("refull_wpt", 32'(bus.wpt), 32'h19);
        chk("refull_level", 32'(bus.wlevel), 32'd16);
        #1;
        chk("refull_gnt", 32'(bus.gnt), 32'h0);

        // 5. wrap-around: 40 writes, read pointer following with a lag
        do_reset();
        bus.req     = 3'b111;
        bus.rp2_wpt = '0;
        d1          = '0;
        for (int k = 0; k < 40; k++) begin
            #1;
            chk($sformatf("wrap_gnt%0d", k),  32'(bus.gnt), 32'(3'b001 << (k % 3)));
            chk($sformatf("wrap_dat%0d", k),  32'(bus.wdata), 32'(slice_val[k % 3]));
            chk($sformatf("wrap_addr%0d", k), 32'(bus.waddr), 32'(k % 16));
            tick();
            chk($sformatf("wrap_wpt%0d", k),  32'(bus.wpt), 32'(gray((k + 1) % 32)));
            chk($sformatf("wrap_full%0d", k), 32'(bus.wfull), 32'h0);
            bus.rp2_wpt = d1;
            d1          = bus.wpt;
        end

        // 6. reset after 9 writes alternating 0/1; the next grant would be 1 without reset
        do_reset();
        bus.req     = 3'b011;
        bus.rp2_wpt = '0;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("mid_gnt%0d", k), 32'(bus.gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
        end
        chk("mid_wpt9", 32'(bus.wpt), 32'h0D);
        chk("mid_level9", 32'(bus.wlevel), 32'd9);
        WRST = 1'b1;
        #1;
        chk("mid_rst_gnt", 32'(bus.gnt), 32'h0);
        chk("mid_rst_wen", 32'(bus.wen), 32'h0);
        tick();
        WRST = 1'b0;
        chk("mid_wpt", 32'(bus.wpt), 32'h0);
        chk("mid_level", 32'(bus.wlevel), 32'h0);
        #1;
        chk("mid_restart_gnt", 32'(bus.gnt), 32'h1);
        tick();
        chk("mid_restart_wpt", 32'(bus.wpt), 32'h1);
        #1;
        chk("mid_next_gnt", 32'(bus.gnt), 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
